design_select_loader: RTL
=========================

DESIGN_SELECT_LOADER -- requirements
Module: design_select_loader

Interface
REQ-001 Parameter DEFAULT_SEL, 6'd1, design slot selected out of reset.
REQ-002 Parameter DEFAULT_HOLD, 1'b0, hold_if_not_sel value out of reset.
REQ-003 Parameter SWITCH_RST_CYCLES, 16, length of the reset pulse issued on a selection change; legal range 1..255.
REQ-004 clock  input  1  single clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_sclk  input  1  asynchronous serial config clock from a pin.
REQ-007 cfg_sdata  input  1  serial config data, MSB first.
REQ-008 cfg_latch  input  1  asynchronous commit strobe.
REQ-009 des_sel  output  6  selected design slot, fed to the mux.
REQ-010 hold_if_not_sel  output  1  hold-deselected-designs flag, fed to the mux.
REQ-011 switch_reset  output  1  high while the newly selected design is held in reset.
REQ-012 busy  output  1  high outside IDLE.
REQ-013 cfg_err  output  1  sticky: last commit was rejected.

Function
REQ-014 cfg_sclk, cfg_sdata and cfg_latch SHALL each pass a 2-flop synchronizer; a rising edge is the synchronized value high with its previous sample low.
REQ-015 Frame SHALL be 8 bits: [7] hold, [6:1] sel, [0] odd parity over [7:1]; bits are captured on synchronized cfg_sclk rising edges.
REQ-016 A 4-bit bit counter SHALL increment per captured bit, saturate at 9, and clear on every commit attempt.
REQ-017 States SHALL be IDLE, SHIFT, SWITCH.
REQ-018 IDLE -> SHIFT on the first cfg_sclk edge; the bit is captured in that same cycle.
REQ-019 SHIFT -> IDLE on a cfg_latch edge; commit is accepted only if counter == 8 and parity is odd.
REQ-020 On an accepted commit, des_sel and hold_if_not_sel SHALL update on the next clock edge.
REQ-021 An accepted commit that changes des_sel SHALL go to SWITCH instead of IDLE; switch_reset is high for exactly SWITCH_RST_CYCLES cycles starting the same cycle des_sel changes, then the FSM returns to IDLE.
REQ-022 An accepted commit with an unchanged des_sel SHALL update hold_if_not_sel only, with no switch_reset.
REQ-023 A rejected commit (counter != 8, counter saturated, or even parity) SHALL leave des_sel and hold_if_not_sel unchanged and set cfg_err.
REQ-024 An accepted commit SHALL clear cfg_err.
REQ-025 In SWITCH, cfg_sclk and cfg_latch edges SHALL be ignored.
REQ-026 A cfg_latch edge in IDLE SHALL set cfg_err (zero bits received).
REQ-027 Simultaneous cfg_sclk and cfg_latch edges in SHIFT: the latch SHALL win and that bit is discarded.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 Selection of slot 0 (unpopulated) SHALL be accepted like any other value.

Reset
REQ-030 Reset SHALL set des_sel=DEFAULT_SEL, hold_if_not_sel=DEFAULT_HOLD, switch_reset=0, cfg_err=0, busy=0, state=IDLE, counter=0, shift register=0, and all synchronizer flops=0.
REQ-031 Reset asserted mid-SHIFT or mid-SWITCH SHALL abort immediately; switch_reset deasserts on the next edge.
REQ-032 After reset is released, cfg pins that are already high SHALL NOT produce an edge until they have been seen low.

Verification
REQ-033 Shift 8'b1_010110_0 (hold=1, sel=22, parity 0 makes 4 ones, even) then latch -> rejected: cfg_err=1, des_sel stays 1.
REQ-034 Shift 8'b1_010110_1 then latch -> des_sel=22, hold=1, cfg_err=0; switch_reset high for exactly 16 cycles, then busy=0.
REQ-035 Send the same sel=22 frame with hold=0 (8'b0_010110_0) -> hold_if_not_sel=0, switch_reset never asserts.
REQ-036 Shift 7 bits and latch; then shift 9 bits and latch -> both rejected, cfg_err=1, des_sel unchanged.
REQ-037 Assert reset in the 5th cycle of SWITCH -> next cycle switch_reset=0, des_sel=DEFAULT_SEL, busy=0.
REQ-038 Toggle cfg_sclk 3 times during SWITCH, then send a valid frame -> exactly 8 bits counted and the frame is accepted.

Source files
------------

// File: rtl/design_select_loader.sv
// Serial design-slot selector: synchronizes an async 3-wire config port, validates 8-bit frames and
// applies them one cycle after the commit; a slot change holds the new design in reset for a fixed pulse.
module design_select_loader #(
  parameter logic [5:0] DEFAULT_SEL       = 6'd1,
  parameter logic       DEFAULT_HOLD      = 1'b0,
  parameter int         SWITCH_RST_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_sclk,
  input  logic       cfg_sdata,
  input  logic       cfg_latch,
  output logic [5:0] des_sel,
  output logic       hold_if_not_sel,
  output logic       switch_reset,
  output logic       busy,
  output logic       cfg_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, SWITCH} state_t;

  localparam logic [7:0] SW_LOAD = 8'(SWITCH_RST_CYCLES - 1);

  // Synchronizer bit order: [0]=sclk, [1]=sdata, [2]=latch
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;
  logic [1:0] vld_q, vld_d;
  logic [1:0] armed_q, armed_d;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] sw_cnt_q, sw_cnt_d;
  logic [5:0] sel_q, sel_d;
  logic       hold_q, hold_d;
  logic       err_q, err_d;

  logic       sclk_rise;
  logic       latch_rise;
  logic       accept;

  // A pin only arms once a genuinely synchronized sample has shown it low,
  // so a pin already high when reset releases cannot fake an edge.
  always_comb begin
    meta_d     = {cfg_latch, cfg_sdata, cfg_sclk};
    sync_d     = meta_q;
    prev_d     = {sync_q[2], sync_q[0]};
    vld_d      = {vld_q[0], 1'b1};
    armed_d    = armed_q | ({2{vld_q[1]}} & ~{sync_q[2], sync_q[0]});
    sclk_rise  = sync_q[0] & ~prev_q[0] & armed_q[0];
    latch_rise = sync_q[2] & ~prev_q[1] & armed_q[1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    sw_cnt_d = sw_cnt_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    err_d    = err_q;
    accept   = (cnt_q == 4'd8) && (^sr_q);

    case (state_q)
      IDLE: begin
        if (latch_rise) begin
          err_d = 1'b1;
          cnt_d = 4'd0;
        end else if (sclk_rise) begin
          state_d = SHIFT;
          sr_d    = {sr_q[6:0], sync_q[1]};
          cnt_d   = 4'd1;
        end
      end
      SHIFT: begin
        // Latch has priority: a coincident clock bit is dropped.
        if (latch_rise) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (accept) begin
            sel_d  = sr_q[6:1];
            hold_d = sr_q[7];
            err_d  = 1'b0;
            if (sr_q[6:1] != sel_q) begin
              state_d  = SWITCH;
              sw_cnt_d = SW_LOAD;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          sr_d = {sr_q[6:0], sync_q[1]};
          if (cnt_q != 4'd9) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      SWITCH: begin
        if (sw_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          sw_cnt_d = sw_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q   <= 3'b000;
      sync_q   <= 3'b000;
      prev_q   <= 2'b00;
      vld_q    <= 2'b00;
      armed_q  <= 2'b00;
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      sr_q     <= 8'd0;
      sw_cnt_q <= 8'd0;
      sel_q    <= DEFAULT_SEL;
      hold_q   <= DEFAULT_HOLD;
      err_q    <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      sw_cnt_q <= sw_cnt_d;
      sel_q    <= sel_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
    end
  end

  assign des_sel         = sel_q;
  assign hold_if_not_sel = hold_q;
  assign cfg_err         = err_q;
  assign switch_reset    = (state_q == SWITCH);
  assign busy            = (state_q != IDLE);

endmodule
